// File: rtl/addsub_step_counter_if.sv
// Control/status bundle for addsub_step_counter: step commands in, registered count and flags out.
interface addsub_step_counter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              en;
  logic              mode;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              zero;

  modport master (
    output en, mode, step, load, load_val,
    input  count, wrap, zero
  );

  modport slave (
    input  en, mode, step, load, load_val,
    output count, wrap, zero
  );
endinterface

// File: rtl/addsub_step_counter.sv
// Registered up/down step counter on a two's-complement add/sub datapath.
// Define ADDSUB_SATURATE_EN to clamp at 0 / 2^WIDTH-1 instead of wrapping.
module addsub_step_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STEP_W  = 4,
  parameter int unsigned RST_VAL = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  addsub_step_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             c;
  logic [WIDTH-1:0] s;
  logic             wrap_next;
  logic [WIDTH-1:0] step_res;

  // Subtraction is count + ~ext + 1; mode doubles as the carry-in.
  always_comb begin
    ext       = WIDTH'(bus.step);
    b         = ext ^ {WIDTH{bus.mode}};
    sum       = {1'b0, count_q} + {1'b0, b} + (WIDTH + 1)'(bus.mode);
    c         = sum[WIDTH];
    s         = sum[WIDTH-1:0];
    // Down-counting borrows when the inverted-operand add produces no carry.
    wrap_next = bus.mode ? ~c : c;
`ifdef ADDSUB_SATURATE_EN
    if (wrap_next) begin
      step_res = bus.mode ? '0 : '1;
    end else begin
      step_res = s;
    end
`else
    step_res  = s;
`endif
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    zero_d  = zero_q;
    if (bus.load) begin
      count_d = bus.load_val;
      zero_d  = (bus.load_val == '0);
    end else if (bus.en) begin
      count_d = step_res;
      wrap_d  = wrap_next;
      zero_d  = (step_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RstCount;
      wrap_q  <= 1'b0;
      zero_q  <= (RstCount == '0);
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_addsub_step_counter.sv
// Randomized bench for addsub_step_counter with an integer-arithmetic reference model.
// Honours ADDSUB_SATURATE_EN the same way as the design.
module tb_addsub_step_counter;

  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 4;
  localparam int          MAXV = (1 << W) - 1;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  addsub_step_counter_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  addsub_step_counter #(
    .WIDTH  (W),
    .STEP_W (SW),
    .RST_VAL(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer add/subtract, range test for wrap.
  int   m_count;
  logic m_wrap;
  logic m_zero;

  function automatic void model_step(input int c, input logic md, input int st,
                                     output int nc, output logic w);
    int r;
    r = md ? c - st : c + st;
    w = (r < 0) || (r > MAXV);
`ifdef ADDSUB_SATURATE_EN
    if (w) nc = md ? 0 : MAXV;
    else   nc = r;
`else
    nc = (r + MAXV + 1) % (MAXV + 1);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int   nc;
    logic w;
    if (!rst_n) begin
      m_count <= 0;
      m_wrap  <= 1'b0;
      m_zero  <= 1'b1;
    end else if (bus.load) begin
      m_count <= int'(bus.load_val);
      m_wrap  <= 1'b0;
      m_zero  <= (bus.load_val == 0);
    end else if (bus.en) begin
      model_step(m_count, bus.mode, int'(bus.step), nc, w);
      m_count <= nc;
      m_wrap  <= w;
      m_zero  <= (nc == 0);
    end else begin
      m_wrap  <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_count", int'(bus.count), m_count);
      chk("cyc_wrap", int'(bus.wrap), int'(m_wrap));
      chk("cyc_zero", int'(bus.zero), int'(m_zero));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    bus.step     = '0;
    bus.load     = 1'b0;
    bus.load_val = '0;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = W'(v);
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic do_step(input logic md, input int st);
    bus.en   = 1'b1;
    bus.mode = md;
    bus.step = SW'(st);
    tick();
    bus.en   = 1'b0;
  endtask

  task automatic pin(input string name, input int cnt, input int wr, input int zr);
    chk({name, "_count"}, int'(bus.count), cnt);
    chk({name, "_wrap"}, int'(bus.wrap), wr);
    chk({name, "_zero"}, int'(bus.zero), zr);
    chk({name, "_model"}, m_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_on = 1'b1;
    pin("reset", 0, 0, 1);

    // Asynchronous reset mid-count.
    do_load(8'h37);
    pin("pre_rst", 8'h37, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    pin("async_rst", 0, 0, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pin("hold_idle", 0, 0, 1);
    end

    // Up wrap: 250 + 10.
    do_load(250);
    do_step(1'b0, 10);
`ifdef ADDSUB_SATURATE_EN
    pin("up_wrap", 255, 1, 0);
    tick();
    pin("up_wrap_after", 255, 0, 0);
`else
    pin("up_wrap", 4, 1, 0);
    tick();
    pin("up_wrap_after", 4, 0, 0);
`endif

    // Down to exactly zero, then borrow.
    do_load(5);
    do_step(1'b1, 5);
    pin("down_zero", 0, 0, 1);
    do_step(1'b1, 3);
`ifdef ADDSUB_SATURATE_EN
    pin("down_borrow", 0, 1, 1);
`else
    pin("down_borrow", 253, 1, 0);
`endif

    // Addition overflow landing on zero.
    do_load(250);
    do_step(1'b0, 6);
`ifdef ADDSUB_SATURATE_EN
    pin("up_to_zero", 255, 1, 0);
`else
    pin("up_to_zero", 0, 1, 1);
`endif

    // 3 - 5.
    do_load(3);
    do_step(1'b1, 5);
`ifdef ADDSUB_SATURATE_EN
    pin("three_minus_five", 0, 1, 1);
`else
    pin("three_minus_five", 254, 1, 0);
`endif

    // Load has priority over a simultaneous enabled step.
    bus.load     = 1'b1;
    bus.load_val = 8'h80;
    bus.en       = 1'b1;
    bus.mode     = 1'b1;
    bus.step     = 4'd15;
    tick();
    idle();
    pin("load_prio", 8'h80, 0, 0);

    // Zero step in down mode never borrows.
    do_step(1'b1, 0);
    pin("step0_down", 8'h80, 0, 0);
    do_load(0);
    do_step(1'b1, 0);
    pin("step0_down_at0", 0, 0, 1);

    // Random sweep.
    for (int i = 0; i < 2000; i++) begin
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.mode     = 1'($urandom_range(0, 1));
      bus.step     = SW'($urandom);
      bus.load     = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_val = W'($urandom_range(0, 4));
        1:       bus.load_val = W'($urandom_range(MAXV - 4, MAXV));
        default: bus.load_val = W'($urandom);
      endcase
      tick();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    idle();
    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_step_counter.md
Name: addsub_step_counter

Overview:
- Parametrised, registered up/down counter built around a WIDTH-bit two's-complement add/subtract datapath.
- Generalises the fixed 5-bit add/sub structure in three ways:
  - width and step size are parameters;
  - the subtract path applies the inverted operand plus carry-in;
  - the sum is held in a state register with load, enable, wrap and borrow signalling.
- Sits in the counter structure library as the general counting primitive for timers and address generators.

Parameters:
- WIDTH, 8, counter and datapath width in bits (legal range 2..32).
- STEP_W, 4, width of the step input (1..WIDTH); zero-extended to WIDTH internally.
- RST_VAL, 0, count value loaded by reset (must fit in WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; a step is applied on each clk edge where en=1.
- mode  input  1  0 = count up (add step), 1 = count down (subtract step).
- step  input  STEP_W  magnitude added or subtracted per enabled cycle.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  WIDTH  value written on load.
- count  output  WIDTH  registered counter value.
- wrap  output  1  registered one-cycle pulse: up-count carried out of MSB, or down-count borrowed below 0.
- zero  output  1  registered flag, 1 when the count register holds 0.

Behaviour:
- Reset (rst_n=0, asynchronous): count=RST_VAL, wrap=0, zero=(RST_VAL==0). Reset can be asserted mid-count in any cycle; it overrides everything, and outputs update without waiting for a clk edge.
- Datapath, evaluated on every cycle:
  - ext = zero-extended step.
  - b = ext XOR {WIDTH{mode}}.
  - {c, s} = count + b + mode, computed in WIDTH+1 bits.
  - The mode-gated inverted operand (not the raw step) feeds the adder.
- Carry interpretation:
  - Up (mode=0): c=1 means overflow past 2^WIDTH-1.
  - Down (mode=1): c=0 means borrow, i.e. the result went below 0.
  - wrap_next = mode ? ~c : c.
- Priority per rising edge:
  - load=1: count<=load_val, wrap<=0, zero<=(load_val==0). en and mode are ignored.
  - load=0, en=1: count<=s, wrap<=wrap_next, zero<=(s==0).
  - load=0, en=0: count holds, wrap<=0, zero holds.
- Latency: a one-cycle step. The new count is visible on the edge after the inputs are sampled. wrap is high for exactly one cycle per wrapping step and is never sticky.
- Arithmetic is modulo 2^WIDTH.
  - Example (WIDTH=8): 250 + 10 gives count=4, wrap=1.
  - Example (WIDTH=8): 3 - 5 gives count=254, wrap=1.
- step=0 with en=1: count unchanged, wrap=0. In down mode c=1 here, so there is no borrow.
- Landing exactly on 0 by subtraction (e.g. 5 - 5): count=0, zero=1, wrap=0.
- Landing exactly on 0 by addition overflow (e.g. 250 + 6 at WIDTH=8): count=0, zero=1, wrap=1.
- mode may change on any cycle. Only the value sampled at the edge matters.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined:
  - An enabled step that would set wrap instead clamps count: up to 2^WIDTH-1, down to 0.
  - wrap still pulses for one cycle to report the saturation event.
  - zero reflects the clamped value.
- Undefined: modulo wrap-around as described in Behaviour; no extra logic is synthesised.

Test Plan:
1. Reset: rst_n=0 asserted asynchronously mid-count at count=0x37 -> count=0x00, zero=1 and wrap=0 before the next clk edge; release and hold en=0 for 3 cycles -> count stays 0.
2. Up wrap (WIDTH=8, STEP_W=4): load 250, then mode=0, step=10, en=1 for one cycle -> count=4, wrap=1 for one cycle, then wrap=0 while en=0.
3. Down borrow and zero: load 5, mode=1, step=5, en=1 -> count=0, zero=1, wrap=0; next step of 3 -> count=253, wrap=1, zero=0.
4. Priority: load=1, load_val=0x80, en=1, mode=1, step=15 on the same edge -> count=0x80, wrap=0. The step is ignored.
5. Random sweep: 2000 cycles of random en/mode/step/load compared against a reference model (modulo 256) -> count, wrap and zero match every cycle. Includes step=0 in down mode -> wrap=0.
6. With ADDSUB_SATURATE_EN defined: count=250 + 10 -> count=255, wrap=1; count=3 - 5 -> count=0, zero=1, wrap=1.
